// File: rtl/game_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | game_pkg
// | Opcodes, challenge-word field positions and round FSM encoding.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package game_pkg;

  localparam logic [1:0] OP_BUTTON       = 2'b00;
  localparam logic [1:0] OP_BUTTON_SERVO = 2'b01;
  localparam logic [1:0] OP_SERVO        = 2'b10;
  localparam logic [1:0] OP_SENSOR       = 2'b11;

  localparam int c_word_w   = 60;
  localparam int c_op_msb   = 59;
  localparam int c_op_lsb   = 58;
  localparam int c_leds_msb = 57;
  localparam int c_leds_lsb = 54;
  localparam int c_spos_msb = 53;
  localparam int c_spos_lsb = 52;
  localparam int c_linf_msb = 51;
  localparam int c_linf_lsb = 40;
  localparam int c_lsup_msb = 39;
  localparam int c_lsup_lsb = 28;
  localparam int c_exp_msb  = 27;
  localparam int c_exp_lsb  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | timeout_counter
// | Cycle counter with synchronous clear; tc pulses on the last counted cycle.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int             c_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_w-1:0] c_last = c_w'(TIMEOUT_CYCLES - 1);

  logic [c_w-1:0] r_count;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + c_w'(1);
    end
  end

  assign tc = enable && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/round_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | round_controller
// | Walks the challenge ROM, presents each word, judges answers, counts score.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module round_controller
  import game_pkg::*;
#(
  parameter int N_ROUNDS       = 8,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [2:0]  mem_address,
  input  logic [59:0] mem_data,
  input  logic [27:0] answer,
  input  logic        answer_valid,
  output logic [1:0]  opcode,
  output logic [3:0]  leds,
  output logic [1:0]  servo_pos,
  output logic [11:0] servo_lim_inf,
  output logic [11:0] servo_lim_sup,
  output logic        round_active,
  output logic [3:0]  hits,
  output logic [3:0]  misses,
  output logic        last_hit,
  output logic        done
);

  localparam logic [2:0] c_last_idx = 3'(N_ROUNDS - 1);

  state_t              r_state, w_state;
  logic [2:0]          r_index, w_index;
  logic [c_word_w-1:0] r_word, w_word;
  logic [3:0]          r_hits, w_hits;
  logic [3:0]          r_misses, w_misses;
  logic                r_last_hit, w_last_hit;
  logic                w_tc, w_timer_clr, w_in_wait, w_hit, w_scored;

  assign w_in_wait   = (r_state == ST_WAIT);
  assign w_timer_clr = !reset || !w_in_wait;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock (clock),
    .clear (w_timer_clr),
    .enable(w_in_wait),
    .tc    (w_tc)
  );

  // Sensor rounds only need some non-zero reading; other opcodes need an exact match.
  assign w_hit = (r_word[c_op_msb:c_op_lsb] == OP_SENSOR) ? (answer != '0)
                                                          : (answer == r_word[c_exp_msb:c_exp_lsb]);
  assign w_scored = answer_valid && w_hit;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_word     <= '0;
      r_hits     <= '0;
      r_misses   <= '0;
      r_last_hit <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_index    <= w_index;
      r_word     <= w_word;
      r_hits     <= w_hits;
      r_misses   <= w_misses;
      r_last_hit <= w_last_hit;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_index    = r_index;
    w_word     = r_word;
    w_hits     = r_hits;
    w_misses   = r_misses;
    w_last_hit = r_last_hit;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state    = ST_LOAD;
          w_index    = '0;
          w_hits     = '0;
          w_misses   = '0;
          w_last_hit = 1'b0;
        end
      end
      ST_LOAD: begin
        w_word  = mem_data;
        w_state = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid answer on the timeout cycle takes precedence over the timeout.
        if (answer_valid || w_tc) begin
          w_last_hit = w_scored;
          if (w_scored) begin
            w_hits = r_hits + 4'd1;
          end else begin
            w_misses = r_misses + 4'd1;
          end
          if (r_index == c_last_idx) begin
            w_state = ST_DONE;
          end else begin
            w_index = r_index + 3'd1;
            w_state = ST_LOAD;
          end
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign mem_address   = r_index;
  assign opcode        = r_word[c_op_msb:c_op_lsb];
  assign leds          = w_in_wait ? r_word[c_leds_msb:c_leds_lsb] : 4'd0;
  assign servo_pos     = r_word[c_spos_msb:c_spos_lsb];
  assign servo_lim_inf = r_word[c_linf_msb:c_linf_lsb];
  assign servo_lim_sup = r_word[c_lsup_msb:c_lsup_lsb];
  assign round_active  = w_in_wait;
  assign hits          = r_hits;
  assign misses        = r_misses;
  assign last_hit      = r_last_hit;
  assign done          = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_round_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_round_controller
// | Stub-ROM bench with a scoreboard of per-round verdicts.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module tb_round_controller;
  import game_pkg::*;

  localparam int TO    = 10;
  localparam int M_ANS = 0;
  localparam int M_TO  = 1;
  localparam int M_SIM = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        answer_valid = 1'b0;
  logic [27:0] answer = '0;
  logic [2:0]  mem_address;
  logic [59:0] mem_data;
  logic [1:0]  opcode;
  logic [3:0]  leds;
  logic [1:0]  servo_pos;
  logic [11:0] servo_lim_inf;
  logic [11:0] servo_lim_sup;
  logic        round_active;
  logic [3:0]  hits;
  logic [3:0]  misses;
  logic        last_hit;
  logic        done;

  logic [59:0] rom [8];
  assign mem_data = rom[mem_address];

  always #5 clock = ~clock;

  round_controller #(.N_ROUNDS(8), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_address(mem_address), .mem_data(mem_data),
    .answer(answer), .answer_valid(answer_valid),
    .opcode(opcode), .leds(leds), .servo_pos(servo_pos),
    .servo_lim_inf(servo_lim_inf), .servo_lim_sup(servo_lim_sup),
    .round_active(round_active), .hits(hits), .misses(misses),
    .last_hit(last_hit), .done(done)
  );

  typedef struct packed {
    logic [3:0] hits;
    logic [3:0] misses;
    logic       last_hit;
    logic [2:0] addr;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_hits = 0;
  int   m_misses = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [59:0] mk(input logic [1:0] op, input logic [3:0] l,
                                     input logic [1:0] p, input logic [11:0] inf,
                                     input logic [11:0] sup, input logic [27:0] e);
    return {op, l, p, inf, sup, e};
  endfunction

  function automatic logic exp_hit(input logic [59:0] w, input logic [27:0] a);
    if (w[59:58] == 2'b11) return (a != 28'd0);
    return (a == w[27:0]);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 ns into the LOAD cycle.
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  // Entered and left 1 ns into a LOAD cycle (left in LOAD of the next round or DONE).
  task automatic play(input int idx, input int mode, input logic [27:0] ans, input bit lpulse);
    logic [59:0] w;
    logic        hit;
    exp_t        e;
    int          nwait;
    w = rom[idx];
    chk("addr_load", 64'(mem_address), 64'(idx));
    chk("leds_load", {leds, round_active}, 0);
    if (lpulse) begin
      start = 1'b1;
      answer_valid = 1'b1;
      answer = w[27:0];
    end
    tick();
    start = 1'b0;
    answer_valid = 1'b0;
    answer = '0;
    chk("fields", {opcode, leds, servo_pos, servo_lim_inf, servo_lim_sup, round_active}, {w[59:28], 1'b1});
    nwait = (mode == M_ANS) ? 3 : TO - 1;
    repeat (nwait) @(posedge clock);
    #1;
    chk("active_pre", round_active, 1);
    if (mode != M_TO) begin
      answer = ans;
      answer_valid = 1'b1;
    end
    hit = (mode != M_TO) && exp_hit(w, ans);
    if (hit) m_hits++;
    else m_misses++;
    e.hits     = 4'(m_hits);
    e.misses   = 4'(m_misses);
    e.last_hit = hit;
    e.addr     = (idx == 7) ? 3'(idx) : 3'(idx + 1);
    e.done     = (idx == 7);
    sb.push_back(e);
    tick();
    answer_valid = 1'b0;
    answer = '0;
    chk("active_fall", round_active, 0);
    e = sb.pop_front();
    chk("hits", hits, e.hits);
    chk("misses", misses, e.misses);
    chk("last_hit", last_hit, e.last_hit);
    chk("addr_next", mem_address, e.addr);
    chk("done", done, e.done);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rom[0] = mk(OP_BUTTON,       4'h1, 2'd0, 12'h010, 12'h090, 28'h0000001);
    rom[1] = mk(OP_BUTTON_SERVO, 4'h2, 2'd1, 12'h020, 12'h180, 28'h0000ABC);
    rom[2] = mk(OP_SERVO,        4'h4, 2'd2, 12'h045, 12'h135, 28'h1234567);
    rom[3] = mk(OP_SENSOR,       4'h8, 2'd3, 12'h000, 12'h999, 28'h0000001);
    rom[4] = mk(OP_BUTTON,       4'hF, 2'd0, 12'h100, 12'h200, 28'hFFFFFFF);
    rom[5] = mk(OP_SENSOR,       4'h3, 2'd1, 12'h250, 12'h375, 28'h5555555);
    rom[6] = mk(OP_BUTTON_SERVO, 4'h6, 2'd2, 12'h321, 12'h654, 28'h0F0F0F0);
    rom[7] = mk(OP_SERVO,        4'h9, 2'd3, 12'h987, 12'h999, 28'hA5A5A5A);

    repeat (3) tick();
    chk("reset", {mem_address, opcode, leds, servo_pos, servo_lim_inf, servo_lim_sup,
                  round_active, hits, misses, last_hit, done}, 0);
    reset = 1'b1;
    tick();
    chk("idle", {round_active, done}, 0);

    // Game 1: every answer correct, 5 cycles per round.
    do_start();
    for (int i = 0; i < 8; i++) play(i, M_ANS, rom[i][27:0], 1'b0);
    tick();
    chk("done_hold", {done, hits, misses}, {1'b1, 4'd8, 4'd0});

    // Game 2: restart from DONE, mixed verdicts, ignored LOAD-cycle pulses.
    do_start();
    chk("clear", {hits, misses, last_hit, done}, 0);
    play(0, M_ANS, 28'h0000002, 1'b0);
    play(1, M_ANS, rom[1][27:0], 1'b1);
    play(2, M_TO,  28'h0,        1'b0);
    play(3, M_SIM, 28'h0000001,  1'b1);
    play(4, M_ANS, 28'h0000000,  1'b0);
    play(5, M_ANS, 28'h0000000,  1'b0);
    play(6, M_ANS, rom[6][27:0], 1'b0);
    play(7, M_SIM, rom[7][27:0], 1'b0);

    // Game 3: reset during round 3 WAIT, then replay from address 0.
    do_start();
    for (int i = 0; i < 3; i++) play(i, M_ANS, rom[i][27:0], 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("reset_mid", {mem_address, opcode, leds, servo_pos, servo_lim_inf, servo_lim_sup,
                      round_active, hits, misses, last_hit, done}, 0);
    tick();
    chk("idle_after_reset", {round_active, done, mem_address}, 0);
    do_start();
    play(0, M_TO, 28'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
